// File: rtl/fei4_rx_scheduler_if.sv
// Bus bundle between the fei4_rx channel FIFOs, the scheduler and the 32-bit output path.
// The scheduler uses the master modport; the environment driving it uses slave.
interface fei4_rx_scheduler_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]    CH_ENABLE;
    logic [WIDTH-1:0]    CH_EMPTY;
    logic [32*WIDTH-1:0] CH_DATA;
    logic [WIDTH-1:0]    CH_READ;
    logic [31:0]         OUT_DATA;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [WIDTH-1:0]    GRANT;
    logic                BUSY;
    logic                DBG_STATE;

    // OUT_VALID/OUT_READY: a word transfers on a clock edge where both are high; while
    // OUT_VALID is high and OUT_READY low, OUT_DATA is held stable.
    modport master (
        input  CH_ENABLE, CH_EMPTY, CH_DATA, OUT_READY,
        output CH_READ, OUT_DATA, OUT_VALID, GRANT, BUSY, DBG_STATE
    );

    modport slave (
        output CH_ENABLE, CH_EMPTY, CH_DATA, OUT_READY,
        input  CH_READ, OUT_DATA, OUT_VALID, GRANT, BUSY, DBG_STATE
    );
endinterface

// File: rtl/fei4_rx_scheduler.sv
// Round-robin burst scheduler draining WIDTH FWFT channel FIFOs into one registered 32-bit stream.
// Optional macro SCHED_PRIO0_EN gives channel 0 strict priority over the round robin.
module fei4_rx_scheduler #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    fei4_rx_scheduler_if.master  bus
);
    localparam int GW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] bc_q, bc_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

    logic [WIDTH-1:0] req;
    logic             room;
    logic             pop;
    logic             end_burst;
    logic             pick_found;
    logic [GW-1:0]    pick_idx;
    logic [GW:0]      cand_sum;
    logic [31:0]      ch_word;
    logic [WIDTH-1:0] ch_read;
    logic [WIDTH-1:0] grant;

    assign req  = bus.CH_ENABLE & ~bus.CH_EMPTY;
    assign room = ~out_valid_q | bus.OUT_READY;
    assign pop  = (state_q == S_GRANT) & req[g_q] & room;

    // Circular search starting one past the last granted channel.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        for (int k = 1; k <= WIDTH; k++) begin
            cand_sum = {1'b0, ptr_q} + (GW+1)'(k);
            if (cand_sum >= (GW+1)'(WIDTH)) cand_sum = cand_sum - (GW+1)'(WIDTH);
            if (!pick_found && req[cand_sum[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        ch_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (g_q == GW'(i)) ch_word = bus.CH_DATA[32*i +: 32];
        end
    end

`ifdef SCHED_PRIO0_EN
    assign end_burst = ~req[g_q] | (pop & (bc_q == BW'(MAX_BURST - 1))) |
                       ((g_q != '0) & req[0]);
`else
    assign end_burst = ~req[g_q] | (pop & (bc_q == BW'(MAX_BURST - 1)));
`endif

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        bc_d        = bc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
`ifdef SCHED_PRIO0_EN
                // Channel-0 grants leave the rotation pointer where it was.
                if (req[0]) begin
                    g_d     = '0;
                    bc_d    = '0;
                    state_d = S_GRANT;
                end else if (pick_found) begin
                    g_d     = pick_idx;
                    ptr_d   = pick_idx;
                    bc_d    = '0;
                    state_d = S_GRANT;
                end
`else
                if (pick_found) begin
                    g_d     = pick_idx;
                    ptr_d   = pick_idx;
                    bc_d    = '0;
                    state_d = S_GRANT;
                end
`endif
            end
            default: begin
                if (pop) bc_d = bc_q + BW'(1);
                if (end_burst) state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            out_data_d  = ch_word;
            out_valid_d = 1'b1;
        end else if (out_valid_q & bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            ptr_q       <= GW'(WIDTH - 1);
            bc_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            bc_q        <= bc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        ch_read = '0;
        grant   = '0;
        if (pop) ch_read[g_q] = 1'b1;
        if (state_q == S_GRANT) grant[g_q] = 1'b1;
    end

    assign bus.CH_READ   = ch_read;
    assign bus.GRANT     = grant;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BUSY      = (state_q == S_GRANT) | out_valid_q;
    assign bus.DBG_STATE = state_q;
endmodule

// File: tb/tb_fei4_rx_scheduler.sv
// Randomized bench for fei4_rx_scheduler: channel FIFO models, a transaction-level grant model
// and a scoreboard of popped words compared against the output stream.
module tb_fei4_rx_scheduler;
  localparam int W  = 4;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fei4_rx_scheduler_if #(.WIDTH(W)) bus ();

  fei4_rx_scheduler #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .BUS_CLK  (clk),
    .BUS_RST_N(rst_n),
    .bus      (bus.master)
  );

  logic [31:0] chq [W][$];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int rdy_pct = 100;
  logic [W-1:0] en = '0;
  int word_id = 0;

  // grant model state
  int model_ptr = W - 1;
  int cur_ch = -1;
  int burst_cnt = 0;
  int exp_len = 0;
  bit expect_end = 0;
  bit cut = 0;
  int grants_seen [W];
  logic [W-1:0] prev_grant = '0;
  logic [W-1:0] prev_req = '0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_next(input logic [W-1:0] r, input int ptr);
`ifdef SCHED_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= W; k++) begin
      if (r[(ptr + k) % W]) return (ptr + k) % W;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < W; i++) begin
      bus.CH_EMPTY[i] = (chq[i].size() == 0);
      bus.CH_DATA[32*i +: 32] = (chq[i].size() != 0) ? chq[i][0] : 32'h0;
    end
    bus.CH_ENABLE = en;
    bus.OUT_READY = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic fill(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      chq[ch].push_back({8'(ch), 24'(word_id)});
      word_id++;
    end
  endtask

  task automatic tick();
    logic [W-1:0] r, g, rd, exp_rd;
    logic room;
    int nxt;
    @(negedge clk);
    r  = bus.CH_ENABLE & ~bus.CH_EMPTY;
    g  = bus.GRANT;
    rd = bus.CH_READ;
    if (!rst_n) begin
      check("rst_grant", g, 0);
      check("rst_read", rd, 0);
      check("rst_valid", bus.OUT_VALID, 0);
      check("rst_data", bus.OUT_DATA, 0);
      check("rst_busy", bus.BUSY, 0);
    end else begin
      if (expect_end) check("burst_end", g, 0);
      expect_end = 0;
      if (prev_grant == 0 && prev_req != 0) check("idle_gap", g != 0, 1);
      if (prev_grant == 0 && g != 0) begin
        nxt = pick_next(prev_req, model_ptr);
        if (nxt < 0) begin
          check("grant_spurious", g, 0);
          cur_ch = -1;
        end else begin
          check("grant_ch", g, W'(1) << nxt);
          cur_ch = nxt;
          grants_seen[nxt]++;
`ifdef SCHED_PRIO0_EN
          if (nxt != 0) model_ptr = nxt;
`else
          model_ptr = nxt;
`endif
          burst_cnt = 0;
          exp_len = (chq[nxt].size() < MB) ? chq[nxt].size() : MB;
          cut = 0;
        end
      end else if (prev_grant != 0 && g != 0) begin
        check("grant_hold", g, prev_grant);
      end
      if (prev_grant != 0 && g == 0 && !cut) check("burst_len", burst_cnt, exp_len);

      room = !bus.OUT_VALID || bus.OUT_READY;
      exp_rd = '0;
      if (g != 0 && cur_ch >= 0 && r[cur_ch] && room) exp_rd = W'(1) << cur_ch;
      check("ch_read", rd, exp_rd);
      check("busy", bus.BUSY, (g != 0) || bus.OUT_VALID);

      if (prev_valid && !prev_ready) begin
        check("hold_valid", bus.OUT_VALID, 1);
        check("hold_data", bus.OUT_DATA, prev_data);
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (exp_q.size() == 0) check("out_extra", 1, 0);
        else check("out_data", bus.OUT_DATA, exp_q.pop_front());
        n_out++;
      end

      if (g != 0 && cur_ch >= 0) begin
        if (!en[cur_ch]) cut = 1;
        if (!r[cur_ch]) expect_end = 1;
`ifdef SCHED_PRIO0_EN
        if (cur_ch != 0 && r[0]) begin
          cut = 1;
          expect_end = 1;
        end
`endif
      end
      for (int i = 0; i < W; i++) begin
        if (rd[i] && chq[i].size() != 0) begin
          exp_q.push_back(chq[i][0]);
          if (i == cur_ch) begin
            burst_cnt++;
            if (burst_cnt == MB) expect_end = 1;
          end
        end
      end
      prev_grant = g;
      prev_req   = r;
      prev_valid = bus.OUT_VALID;
      prev_ready = bus.OUT_READY;
      prev_data  = bus.OUT_DATA;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (rd[i] && chq[i].size() != 0) void'(chq[i].pop_front());
    end
    drive_inputs();
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0) || (bus.GRANT != 0) || bus.OUT_VALID;
    for (int i = 0; i < W; i++) if (en[i] && chq[i].size() != 0) p = 1;
    return p;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  task automatic wait_grant(input logic [W-1:0] want, input int budget);
    int n;
    n = 0;
    while (bus.GRANT != want && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("wait_grant_timeout", 1, 0);
  endtask

  int start;

  initial begin
    for (int i = 0; i < W; i++) grants_seen[i] = 0;
    drive_inputs();
    repeat (3) tick();
    rst_n = 1'b1;

    // empty channels after reset: nothing granted or popped
    en = '1;
    repeat (100) tick();
    check("idle_grant", bus.GRANT, 0);
    check("idle_out", n_out, 0);

    // channel 2 holds A0..A4
    for (int k = 0; k < 5; k++) chq[2].push_back(32'hA0 + 32'(k));
    start = n_out;
    drive_inputs();
    drain(200);
    check("t2_words", n_out - start, 5);

    // all channels, 40 words each
    for (int i = 0; i < W; i++) fill(i, 40);
    start = n_out;
    drive_inputs();
    drain(1000);
    check("t3_words", n_out - start, 160);

    // 30-word burst with random back-pressure
    rdy_pct = 50;
    fill(1, 30);
    start = n_out;
    drive_inputs();
    drain(1000);
    check("t4_words", n_out - start, 30);

    // channel 2 masked; drop enable of channel 1 mid-burst
    rdy_pct = 80;
    en = 4'b1011;
    for (int i = 0; i < W; i++) begin
      fill(i, 20);
      grants_seen[i] = 0;
    end
    drive_inputs();
    wait_grant(4'b0010, 500);
    repeat (2) tick();
    en = 4'b1001;
    bus.CH_ENABLE = en;
    drain(1000);
    check("t5_ch2_never", grants_seen[2], 0);
    en = '1;
    drive_inputs();
    drain(1000);

    // random rounds
    for (int rnd = 0; rnd < 6; rnd++) begin
      en = W'($urandom_range(1, (1 << W) - 1));
      rdy_pct = $urandom_range(30, 100);
      for (int i = 0; i < W; i++) fill(i, $urandom_range(0, 40));
      drive_inputs();
      drain(3000);
    end
    en = '1;
    rdy_pct = 100;
    drive_inputs();
    drain(3000);

`ifdef SCHED_PRIO0_EN
    // channel 0 pre-empts a channel-1 burst
    fill(1, 30);
    drive_inputs();
    wait_grant(4'b0010, 100);
    repeat (3) tick();
    fill(0, 5);
    fill(2, 5);
    drive_inputs();
    drain(1000);
`endif

    for (int i = 0; i < W; i++) check("final_fifo_empty", chq[i].size(), 0);
    check("final_scoreboard", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fei4_rx_scheduler.md
# fei4_rx_scheduler

Round-robin burst scheduler that drains up to WIDTH `fei4_rx` output FIFOs into the single 32-bit data path feeding `fifo_32_to_8` and the SiTCP TX stream. The block grants one channel at a time and pops up to MAX_BURST words from it before rotating. Channels can be masked at run time. Output is a registered valid/ready stage, so no word is lost when the downstream FIFO fills.

## Interface
Parameters:
- WIDTH, 4, number of receiver channels (2..8)
- MAX_BURST, 16, maximum words popped per grant (1..255)

Ports:
- BUS_CLK  in  1  single clock for all logic
- BUS_RST_N  in  1  reset, asynchronous, active-low
- CH_ENABLE  in  WIDTH  per-channel enable mask; disabled channels are never granted
- CH_EMPTY  in  WIDTH  per-channel FIFO empty (first-word-fall-through)
- CH_DATA  in  32*WIDTH  channel i word on bits [32*i+31:32*i], valid while CH_EMPTY[i]=0
- CH_READ  out  WIDTH  pop strobe, one-hot or zero, combinational
- OUT_DATA  out  32  registered output word
- OUT_VALID  out  1  OUT_DATA holds a word
- OUT_READY  in  1  downstream accepts this cycle (= !FIFO_FULL)
- GRANT  out  WIDTH  one-hot registered current grant, 0 in IDLE
- BUSY  out  1  high in GRANT state or while OUT_VALID=1

## Operation
- req[i] = CH_ENABLE[i] & ~CH_EMPTY[i].
- States: IDLE, GRANT. Registers: grant index g, rotation pointer ptr (reset WIDTH-1), burst counter bc (width clog2(MAX_BURST+1), reset 0), output register.
- IDLE: if any req, pick the first requesting index in circular order ptr+1, ptr+2, … ptr. Register g, set ptr=g, clear bc, go to GRANT. Else stay.
- Output register can accept when `room = ~OUT_VALID | OUT_READY`.
- GRANT: pop when `pop = req[g] & room`. CH_READ[g]=pop. On pop, OUT_DATA<=CH_DATA[g], OUT_VALID<=1, bc<=bc+1.
- When OUT_VALID & OUT_READY and no pop, OUT_VALID<=0.
- Burst ends when req[g]=0 (empty or disabled), or when a pop makes bc reach MAX_BURST. Next state is IDLE.
- A stall (room=0) with req[g]=1 holds GRANT, and bc does not advance.
- Reset values: CH_READ=0, OUT_DATA=0, OUT_VALID=0, GRANT=0, BUSY=0, state=IDLE.
- Reset mid-burst discards the registered word. Channel FIFOs are untouched.

## Timing
- A request seen in IDLE at edge n gives GRANT valid after edge n+1. The first CH_READ occurs in cycle n+1, and OUT_VALID=1 after edge n+2.
- Sustained throughput is 1 word/cycle within a burst while OUT_READY=1.
- Burst switch overhead is exactly 1 IDLE cycle, so at most MAX_BURST words per MAX_BURST+1 cycles.
- CH_READ depends combinationally on OUT_READY, CH_EMPTY and CH_ENABLE. There is no other combinational input-to-output path.
- OUT_VALID, once set, holds with stable OUT_DATA until OUT_READY=1.
- Simultaneous pop and downstream accept: new word loaded and OUT_VALID stays 1.
- CH_ENABLE[g] falling mid-burst: no pop that cycle, burst ends, next cycle IDLE.
- MAX_BURST=1: IDLE and GRANT alternate, so peak throughput is 1 word per 2 cycles.

## Configuration
- SCHED_PRIO0_EN defined:
  - Channel 0 has strict priority: in IDLE, req[0] wins regardless of ptr, and ptr is not updated by channel-0 grants.
  - A burst on channel g≠0 ends after the current cycle when req[0]=1.
  - Channel-0 bursts obey MAX_BURST.
- SCHED_PRIO0_EN undefined: pure round-robin as above. Channel 0 has no special handling.

## Test plan
- Reset release with CH_EMPTY=4'b1111 -> GRANT=0, OUT_VALID=0, CH_READ=0 for 100 cycles.
- Channel 2 holds 5 words (0xA0..0xA4), OUT_READY=1, MAX_BURST=16:
  - GRANT=4'b0100 one cycle after request.
  - 5 consecutive CH_READ[2] pulses.
  - OUT_DATA sequence A0..A4, then IDLE.
- All 4 channels hold 40 words each, MAX_BURST=16:
  - Grant order 0,1,2,3,0,1,2,3,0,1,2,3.
  - Bursts of 16,16,8 words per channel.
  - Exactly one IDLE cycle between bursts; 160 words out, none lost or duplicated.
- OUT_READY toggles with random 50% duty during a 30-word burst -> OUT_DATA stable while OUT_VALID & !OUT_READY, no CH_READ when room=0, all 30 words delivered in order.
- CH_ENABLE=4'b1011 with all channels non-empty -> channel 2 never granted; clearing CH_ENABLE[1] mid-burst ends that burst within 1 cycle with no pop.
- With SCHED_PRIO0_EN, channel 1 bursting and channel 0 becoming non-empty -> at most 1 further channel-1 word, then GRANT=4'b0001; ptr resumes at channel 2 afterwards.
